memory_responder: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 31 +++
 rtl/memory_responder.sv | 155 +++++++++++++++
 tb/tb_memory_responder.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-interface types: data word, RAM port status and responder FSM encodings.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Status reported by the RAM model on its single port.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Responder FSM: idle, one access state per requester, one hit state per requester.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IACC  = 3'd1,
        DACC  = 3'd2,
        IDONE = 3'd3,
        DDONE = 3'd4
    } memresp_state_t;

    // Which requester completed the most recent successful access.
    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } grant_t;

endpackage

// File: rtl/memory_responder.sv
// Serialises instruction and data requests onto one RAM port and answers with ihit/dhit pulses.
// Latency: request sampled in IDLE, strobes next cycle, hit the cycle after RAM reports ACCESS (min 2).
// Backpressure: requests are held by the requester until hit; RAM stalls via BUSY/FREE, bounded by TIMEOUT.
module memory_responder
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      imemREN,
    input  word_t     imemaddr,
    input  logic      dmemREN,
    input  logic      dmemWEN,
    input  word_t     dmemaddr,
    input  word_t     dmemstore,
    output logic      ihit,
    output logic      dhit,
    output word_t     imemload,
    output word_t     dmemload,
    output logic      memerr,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    localparam int CW = $clog2(TIMEOUT + 1);

    memresp_state_t state, state_nxt;
    grant_t         last_grant;
    word_t          addr_q;
    word_t          store_q;
    logic           wr_q;
    logic [CW-1:0]  cnt;

    logic grant_i;
    logic grant_d;
    logic acc_ok;
    logic acc_err;
    logic req_held;
    logic timed_out;

    // The counter holds the number of access cycles already completed, so the
    // TIMEOUT-th access cycle is the one that sees cnt == TIMEOUT-1.
    assign timed_out = (cnt == CW'(TIMEOUT - 1));

    // State register; async reset drops the FSM (and so the RAM strobes) at once.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle event decode (grant, completion, error/timeout).
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        acc_ok    = 1'b0;
        acc_err   = 1'b0;
        req_held  = 1'b0;
        case (state)
            IDLE: begin
                // Data normally wins; instruction wins right after a data access so neither starves.
                if ((dmemREN || dmemWEN) && !(last_grant == DATA && imemREN)) begin
                    grant_d   = 1'b1;
                    state_nxt = DACC;
                end else if (imemREN) begin
                    grant_i   = 1'b1;
                    state_nxt = IACC;
                end
            end
            IACC, DACC: begin
                if (state == IACC) begin
                    req_held = imemREN;
                end else begin
                    req_held = wr_q ? dmemWEN : dmemREN;
                end
                // An abandoned request is dropped silently, even if the RAM finishes this cycle.
                if (!req_held) begin
                    state_nxt = IDLE;
                end else if (ramstate == ACCESS) begin
                    acc_ok    = 1'b1;
                    state_nxt = (state == IACC) ? IDONE : DDONE;
                end else if (ramstate == ERROR || timed_out) begin
                    acc_err   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            IDONE, DDONE: begin
                // One cycle for the requester to drop or replace its request before re-arbitration.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latched request, timeout counter, load data, fairness memory and error pulse.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            addr_q     <= '0;
            store_q    <= '0;
            wr_q       <= 1'b0;
            cnt        <= '0;
            imemload   <= '0;
            dmemload   <= '0;
            last_grant <= INSTR;
            memerr     <= 1'b0;
        end else begin
            memerr <= acc_err;
            if (grant_i) begin
                addr_q <= imemaddr;
            end
            if (grant_d) begin
                addr_q  <= dmemaddr;
                store_q <= dmemstore;
                wr_q    <= dmemWEN;
            end
            if (grant_i || grant_d) begin
                cnt <= '0;
            end else if (state == IACC || state == DACC) begin
                cnt <= cnt + CW'(1);
            end
            if (acc_ok) begin
                if (state == IACC) begin
                    imemload   <= ramload;
                    last_grant <= INSTR;
                end else begin
                    if (!wr_q) begin
                        dmemload <= ramload;
                    end
                    last_grant <= DATA;
                end
            end
        end
    end

    // Moore outputs decoded from state and the latched access kind.
    always_comb begin
        ihit     = (state == IDONE);
        dhit     = (state == DDONE);
        ramREN   = (state == IACC) || (state == DACC && !wr_q);
        ramWEN   = (state == DACC) && wr_q;
        ramaddr  = addr_q;
        ramstore = store_q;
    end

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: directed literal scenarios, then randomized requesters and RAM.
// A transaction-level model predicts every output every cycle; one process compares on the falling edge.
// Requests are held until hit (occasionally abandoned or wiggled); RAM status is randomized.
module tb_memory_responder;
    import cpu_types_pkg::*;

    localparam int TO = 4;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      imemREN, dmemREN, dmemWEN;
    word_t     imemaddr, dmemaddr, dmemstore, ramload;
    ramstate_t ramstate;
    logic      ihit, dhit, memerr, ramREN, ramWEN;
    word_t     imemload, dmemload, ramaddr, ramstore;

    memory_responder #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .nRST(nRST),
        .imemREN(imemREN), .imemaddr(imemaddr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .ihit(ihit), .dhit(dhit), .imemload(imemload), .dmemload(dmemload), .memerr(memerr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    localparam int K_NONE = 0, K_I = 1, K_DR = 2, K_DW = 3;
    bit    m_busy;       // an access is on the RAM port this cycle
    int    m_kind;       // which request that access serves
    int    m_done;       // requester being answered this cycle (K_NONE if none)
    int    m_age;        // access cycles spent so far
    bit    m_last_data;  // most recent successful access was data
    bit    m_err;
    word_t m_addr, m_store, m_iload, m_dload;

    function automatic void model_reset();
        m_busy = 0; m_kind = K_NONE; m_done = K_NONE; m_age = 0; m_last_data = 0; m_err = 0;
        m_addr = '0; m_store = '0; m_iload = '0; m_dload = '0;
    endfunction

    // Advance the model by one clock using the inputs present at the edge.
    function automatic void model_step();
        bit held;
        m_err = 0;
        if (m_done != K_NONE) begin
            m_done = K_NONE;
        end else if (m_busy) begin
            m_age++;
            held = (m_kind == K_I) ? imemREN : (m_kind == K_DW) ? dmemWEN : dmemREN;
            if (!held) begin
                m_busy = 0;
            end else if (ramstate == ACCESS) begin
                m_busy = 0;
                m_done = m_kind;
                if (m_kind == K_I) m_iload = ramload;
                if (m_kind == K_DR) m_dload = ramload;
                m_last_data = (m_kind != K_I);
            end else if (ramstate == ERROR || m_age >= TO) begin
                m_busy = 0;
                m_err = 1;
            end
        end else begin
            if ((dmemREN || dmemWEN) && !(m_last_data && imemREN)) begin
                m_busy = 1; m_kind = dmemWEN ? K_DW : K_DR; m_age = 0;
                m_addr = dmemaddr; m_store = dmemstore;
            end else if (imemREN) begin
                m_busy = 1; m_kind = K_I; m_age = 0;
                m_addr = imemaddr;
            end
        end
    endfunction

    // Single compare process: every output against the model, every cycle.
    always @(negedge CLK) begin
        if (chk_en) begin
            cmp("ihit",     32'(ihit),     32'(m_done == K_I));
            cmp("dhit",     32'(dhit),     32'(m_done == K_DR || m_done == K_DW));
            cmp("memerr",   32'(memerr),   32'(m_err));
            cmp("ramREN",   32'(ramREN),   32'(m_busy && m_kind != K_DW));
            cmp("ramWEN",   32'(ramWEN),   32'(m_busy && m_kind == K_DW));
            cmp("ramaddr",  ramaddr,  m_addr);
            cmp("ramstore", ramstore, m_store);
            cmp("imemload", imemload, m_iload);
            cmp("dmemload", dmemload, m_dload);
        end
    end

    task automatic cyc();
        @(posedge CLK);
        if (nRST) model_step();
        @(negedge CLK);
    endtask

    // Pulse reset between clock edges; returns at a falling edge with reset released.
    task automatic reset_dut();
        #2;
        nRST = 1'b0;
        model_reset();
        cyc();
        nRST = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        cmp({tag, "_ihit"},     32'(ihit),   32'd0);
        cmp({tag, "_dhit"},     32'(dhit),   32'd0);
        cmp({tag, "_memerr"},   32'(memerr), 32'd0);
        cmp({tag, "_ramREN"},   32'(ramREN), 32'd0);
        cmp({tag, "_ramWEN"},   32'(ramWEN), 32'd0);
        cmp({tag, "_ramaddr"},  ramaddr,  32'd0);
        cmp({tag, "_ramstore"}, ramstore, 32'd0);
        cmp({tag, "_imemload"}, imemload, 32'd0);
        cmp({tag, "_dmemload"}, dmemload, 32'd0);
    endtask

    int hc[$];
    bit hd[$];
    int wen_cycles;
    int ren_cycles;
    int r;

    initial begin
        nRST = 1'b1; imemREN = 0; dmemREN = 0; dmemWEN = 0;
        imemaddr = '0; dmemaddr = '0; dmemstore = '0; ramload = '0; ramstate = FREE;
        model_reset();
        #1 nRST = 1'b0;
        chk_en = 1'b1;
        cyc(); cyc();
        check_all_zero("reset");
        nRST = 1'b1;

        // Instruction fetch, RAM ready on the first strobe cycle.
        imemREN = 1; imemaddr = 32'h0000_0040; ramstate = ACCESS; ramload = 32'h2002_0001;
        cyc();
        cmp("t1_c1_ramREN", 32'(ramREN), 32'd1);
        cmp("t1_c1_ramaddr", ramaddr, 32'h0000_0040);
        cmp("t1_c1_ihit", 32'(ihit), 32'd0);
        cyc();
        cmp("t1_c2_ihit", 32'(ihit), 32'd1);
        cmp("t1_c2_imemload", imemload, 32'h2002_0001);
        cmp("t1_c2_ramREN", 32'(ramREN), 32'd0);
        imemREN = 0; ramstate = FREE;
        cyc();
        cmp("t1_c3_ihit", 32'(ihit), 32'd0);
        cmp("t1_c3_imemload_held", imemload, 32'h2002_0001);

        // Data write with three BUSY cycles before ACCESS.
        dmemWEN = 1; dmemaddr = 32'h0000_0100; dmemstore = 32'hDEAD_BEEF; ramstate = BUSY;
        wen_cycles = 0;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            if (ramWEN) wen_cycles++;
            cmp("t2_ramstore", ramstore, 32'hDEAD_BEEF);
            cmp("t2_ramaddr", ramaddr, 32'h0000_0100);
            cmp("t2_dhit_early", 32'(dhit), 32'd0);
            // Requester inputs change mid-access; the latched values must not follow.
            dmemaddr = 32'h0000_0999; dmemstore = 32'h1111_1111;
            if (c == 4) begin
                ramstate = ACCESS; ramload = 32'h1234_5678;
            end
        end
        cmp("t2_wen_cycles", wen_cycles, 32'd4);
        cyc();
        cmp("t2_c5_dhit", 32'(dhit), 32'd1);
        cmp("t2_c5_dmemload", dmemload, 32'd0);
        cmp("t2_c5_ramWEN", 32'(ramWEN), 32'd0);
        dmemWEN = 0; ramstate = FREE;
        cyc();

        // Both requesters held from reset: data, instruction, data, one access per 3 cycles.
        reset_dut();
        imemREN = 1; imemaddr = 32'h0000_0200; dmemREN = 1; dmemaddr = 32'h0000_0300;
        ramstate = ACCESS; ramload = 32'h0000_00A0;
        for (int c = 1; c <= 9; c++) begin
            cyc();
            if (ihit) begin hc.push_back(c); hd.push_back(1'b0); end
            if (dhit) begin hc.push_back(c); hd.push_back(1'b1); end
        end
        cmp("t3_hit_count", hc.size(), 32'd3);
        if (hc.size() >= 3) begin
            cmp("t3_first_is_data",  32'(hd[0]), 32'd1);
            cmp("t3_second_is_inst", 32'(hd[1]), 32'd0);
            cmp("t3_third_is_data",  32'(hd[2]), 32'd1);
            cmp("t3_first_cycle",  hc[0], 32'd2);
            cmp("t3_second_cycle", hc[1], 32'd5);
            cmp("t3_third_cycle",  hc[2], 32'd8);
        end

        // Data read hits ERROR, is retried, then completes.
        imemREN = 0; dmemREN = 1; dmemaddr = 32'h0000_0044; ramstate = ERROR;
        cyc();
        cmp("t4_c1_ramREN", 32'(ramREN), 32'd1);
        cmp("t4_c1_ramaddr", ramaddr, 32'h0000_0044);
        cyc();
        cmp("t4_c2_memerr", 32'(memerr), 32'd1);
        cmp("t4_c2_dhit", 32'(dhit), 32'd0);
        cmp("t4_c2_ramREN", 32'(ramREN), 32'd0);
        ramstate = ACCESS; ramload = 32'hCAFE_0001;
        cyc();
        cmp("t4_c3_retry_ramREN", 32'(ramREN), 32'd1);
        cmp("t4_c3_memerr", 32'(memerr), 32'd0);
        cyc();
        cmp("t4_c4_dhit", 32'(dhit), 32'd1);
        cmp("t4_c4_dmemload", dmemload, 32'hCAFE_0001);
        dmemREN = 0;

        // RAM stuck BUSY: timeout after TO strobe cycles, then reset mid-retry.
        imemREN = 1; imemaddr = 32'h0000_0080; ramstate = BUSY;
        cyc();
        ren_cycles = 0;
        for (int c = 1; c <= TO; c++) begin
            cyc();
            if (ramREN) ren_cycles++;
            cmp("t5_memerr_early", 32'(memerr), 32'd0);
        end
        cmp("t5_ren_cycles", ren_cycles, TO);
        cyc();
        cmp("t5_memerr", 32'(memerr), 32'd1);
        cmp("t5_ramREN_dropped", 32'(ramREN), 32'd0);
        cmp("t5_ihit", 32'(ihit), 32'd0);
        cyc();
        cmp("t5_retry_ramREN", 32'(ramREN), 32'd1);
        cyc();
        #2;
        nRST = 1'b0;
        model_reset();
        #1;
        check_all_zero("t5_async_reset");
        cyc();
        nRST = 1'b1;

        // Requester abandons an instruction fetch mid-access.
        ramstate = FREE;
        cyc();
        cmp("t6_ramREN", 32'(ramREN), 32'd1);
        imemREN = 0;
        cyc();
        cmp("t6_abort_ramREN", 32'(ramREN), 32'd0);
        cmp("t6_abort_memerr", 32'(memerr), 32'd0);
        cyc();
        cmp("t6_abort_ihit", 32'(ihit), 32'd0);

        // Randomized requesters and RAM.
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (m_done == K_I) imemREN = 0;
            if (!imemREN && $urandom_range(0, 2) == 0) begin
                imemREN = 1; imemaddr = $urandom;
            end else if (imemREN && $urandom_range(0, 15) == 0) begin
                imemaddr = $urandom;
            end
            if (imemREN && m_done != K_I && $urandom_range(0, 39) == 0) imemREN = 0;

            if (m_done == K_DR || m_done == K_DW) begin dmemREN = 0; dmemWEN = 0; end
            if (!(dmemREN || dmemWEN) && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1) dmemWEN = 1; else dmemREN = 1;
                dmemaddr = $urandom; dmemstore = $urandom;
            end else if ((dmemREN || dmemWEN) && $urandom_range(0, 15) == 0) begin
                dmemaddr = $urandom; dmemstore = $urandom;
            end
            if ((dmemREN || dmemWEN) && !(m_done == K_DR || m_done == K_DW)
                && $urandom_range(0, 39) == 0) begin
                dmemREN = 0; dmemWEN = 0;
            end

            ramload = $urandom;
            r = int'($urandom_range(0, 19));
            if (r < 5)       ramstate = ACCESS;
            else if (r == 5) ramstate = ERROR;
            else if (r < 13) ramstate = BUSY;
            else             ramstate = FREE;
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
